// File: rtl/writeback_arbiter.sv
// Write-side producer for the register file: buffers ALU and LSU results, arbitrates them
// round-robin onto the single RF write port, and exposes a two-port bypass lookup.
module writeback_arbiter #(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter bit DROP_X0 = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            rf_we,
  output logic [AW-1:0]   rf_w_add,
  output logic [XLEN-1:0] rf_w_data,
  input  logic [AW-1:0]   byp_add1,
  input  logic [AW-1:0]   byp_add2,
  output logic            byp_hit1,
  output logic [XLEN-1:0] byp_data1,
  output logic            byp_hit2,
  output logic [XLEN-1:0] byp_data2,
  output logic            busy
);

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  buf_state_t alu_state, alu_state_nxt;
  buf_state_t lsu_state, lsu_state_nxt;

  logic [AW-1:0]   alu_rd_q, lsu_rd_q;
  logic [XLEN-1:0] alu_data_q, lsu_data_q;

  logic rr_lsu;
  logic lsu_younger;

  logic            alu_full, lsu_full;
  logic            alu_accept, lsu_accept;
  logic            grant_alu, grant_lsu, contended;
  logic [AW-1:0]   grant_rd;
  logic [XLEN-1:0] grant_data;

  // rr_lsu=1 means the LSU won the last tie, so the ALU wins the next one.
  always_comb begin
    alu_full   = (alu_state == BUF_FULL);
    lsu_full   = (lsu_state == BUF_FULL);
    alu_ready  = ~alu_full;
    lsu_ready  = ~lsu_full;
    alu_accept = alu_valid & ~alu_full;
    lsu_accept = lsu_valid & ~lsu_full;
    contended  = alu_full & lsu_full;
    grant_alu  = alu_full & (~lsu_full | rr_lsu);
    grant_lsu  = lsu_full & (~alu_full | ~rr_lsu);
    grant_rd   = grant_lsu ? lsu_rd_q   : alu_rd_q;
    grant_data = grant_lsu ? lsu_data_q : alu_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_state <= BUF_EMPTY;
      lsu_state <= BUF_EMPTY;
    end else begin
      alu_state <= alu_state_nxt;
      lsu_state <= lsu_state_nxt;
    end
  end

  // A draining buffer is never refilled on the same edge since ready reflects EMPTY only.
  always_comb begin
    alu_state_nxt = alu_state;
    lsu_state_nxt = lsu_state;
    case (alu_state)
      BUF_EMPTY: if (alu_accept) alu_state_nxt = BUF_FULL;
      BUF_FULL:  if (grant_alu)  alu_state_nxt = BUF_EMPTY;
    endcase
    case (lsu_state)
      BUF_EMPTY: if (lsu_accept) lsu_state_nxt = BUF_FULL;
      BUF_FULL:  if (grant_lsu)  lsu_state_nxt = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_rd_q   <= '0;
      alu_data_q <= '0;
      lsu_rd_q   <= '0;
      lsu_data_q <= '0;
    end else begin
      if (alu_accept) begin
        alu_rd_q   <= alu_rd;
        alu_data_q <= alu_data;
      end
      if (lsu_accept) begin
        lsu_rd_q   <= lsu_rd;
        lsu_data_q <= lsu_data;
      end
    end
  end

  // Pointer only moves on a real tie; the age flag follows the most recent fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_lsu      <= 1'b1;
      lsu_younger <= 1'b0;
    end else begin
      if (contended) rr_lsu <= grant_lsu;
      if (lsu_accept)      lsu_younger <= 1'b1;
      else if (alu_accept) lsu_younger <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we     <= 1'b0;
      rf_w_add  <= '0;
      rf_w_data <= '0;
    end else if (grant_alu | grant_lsu) begin
      rf_we     <= !(DROP_X0 && (grant_rd == '0));
      rf_w_add  <= grant_rd;
      rf_w_data <= grant_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

  assign busy = alu_full | lsu_full | rf_we;

  // Returns {hit, data}; younger buffer beats older buffer beats the output stage.
  function automatic logic [XLEN:0] byp_lookup(input logic [AW-1:0] addr);
    logic alu_match, lsu_match, out_match;
    alu_match = alu_full && (alu_rd_q == addr);
    lsu_match = lsu_full && (lsu_rd_q == addr);
    out_match = rf_we && (rf_w_add == addr);
    if (addr == '0)                  byp_lookup = '0;
    else if (lsu_younger && lsu_match)  byp_lookup = {1'b1, lsu_data_q};
    else if (!lsu_younger && alu_match) byp_lookup = {1'b1, alu_data_q};
    else if (lsu_match)              byp_lookup = {1'b1, lsu_data_q};
    else if (alu_match)              byp_lookup = {1'b1, alu_data_q};
    else if (out_match)              byp_lookup = {1'b1, rf_w_data};
    else                             byp_lookup = '0;
  endfunction

  always_comb begin
    {byp_hit1, byp_data1} = byp_lookup(byp_add1);
    {byp_hit2, byp_data2} = byp_lookup(byp_add2);
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter, checked each cycle against a
// transaction-level model of the two holding buffers, the tie rule and the output stage.
module tb_writeback_arbiter;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid, alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid, lsu_ready;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            rf_we;
  logic [AW-1:0]   rf_w_add;
  logic [XLEN-1:0] rf_w_data;
  logic [AW-1:0]   byp_add1, byp_add2;
  logic            byp_hit1, byp_hit2;
  logic [XLEN-1:0] byp_data1, byp_data2;
  logic            busy;

  always #5 clk = ~clk;

  writeback_arbiter #(.XLEN(XLEN), .AW(AW), .DROP_X0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_we(rf_we), .rf_w_add(rf_w_add), .rf_w_data(rf_w_data),
    .byp_add1(byp_add1), .byp_add2(byp_add2),
    .byp_hit1(byp_hit1), .byp_data1(byp_data1),
    .byp_hit2(byp_hit2), .byp_data2(byp_data2),
    .busy(busy)
  );

  int check_count = 0;
  int pass_count  = 0;

  // Model: index 0 = ALU, 1 = LSU; fill order kept as a sequence stamp.
  logic            m_full [2];
  logic [AW-1:0]   m_rd   [2];
  logic [XLEN-1:0] m_dat  [2];
  int              m_seq  [2];
  int              m_tie_winner;
  logic            m_we;
  logic [AW-1:0]   m_add;
  logic [XLEN-1:0] m_wdata;
  int              cycle_no = 0;

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] got,
                             input logic [XLEN-1:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cycle_no);
  endtask

  task automatic modelReset();
    for (int s = 0; s < 2; s++) begin
      m_full[s] = 1'b0;
      m_rd[s]   = '0;
      m_dat[s]  = '0;
      m_seq[s]  = -1;
    end
    m_tie_winner = 1;
    m_we    = 1'b0;
    m_add   = '0;
    m_wdata = '0;
  endtask

  function automatic logic [XLEN:0] modelBypass(input logic [AW-1:0] addr);
    int order [2];
    if (addr == '0) return '0;
    if (m_seq[1] > m_seq[0]) order = '{1, 0};
    else                     order = '{0, 1};
    for (int k = 0; k < 2; k++)
      if (m_full[order[k]] && m_rd[order[k]] == addr) return {1'b1, m_dat[order[k]]};
    if (m_we && m_add == addr) return {1'b1, m_wdata};
    return '0;
  endfunction

  task automatic applyStimulus(input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] adat,
                               input logic lv, input logic [AW-1:0] lrd, input logic [XLEN-1:0] ldat,
                               input logic [AW-1:0] b1, input logic [AW-1:0] b2);
    logic [XLEN:0] e1, e2;
    int  g;
    bit  tie, acc0, acc1;
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_data = adat;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
    byp_add1 = b1;  byp_add2 = b2;
    #1;
    e1 = modelBypass(b1);
    e2 = modelBypass(b2);
    checkOutput("alu_ready", XLEN'(alu_ready), XLEN'(!m_full[0]));
    checkOutput("lsu_ready", XLEN'(lsu_ready), XLEN'(!m_full[1]));
    checkOutput("rf_we",     XLEN'(rf_we),     XLEN'(m_we));
    checkOutput("rf_w_add",  XLEN'(rf_w_add),  XLEN'(m_add));
    checkOutput("rf_w_data", rf_w_data,        m_wdata);
    checkOutput("busy",      XLEN'(busy),      XLEN'(m_full[0] | m_full[1] | m_we));
    checkOutput("byp_hit1",  XLEN'(byp_hit1),  XLEN'(e1[XLEN]));
    checkOutput("byp_data1", byp_data1,        e1[XLEN-1:0]);
    checkOutput("byp_hit2",  XLEN'(byp_hit2),  XLEN'(e2[XLEN]));
    checkOutput("byp_data2", byp_data2,        e2[XLEN-1:0]);

    tie = m_full[0] && m_full[1];
    g = -1;
    if (tie)            g = (m_tie_winner == 1) ? 0 : 1;
    else if (m_full[0]) g = 0;
    else if (m_full[1]) g = 1;
    acc0 = av && !m_full[0];
    acc1 = lv && !m_full[1];
    if (g >= 0) begin
      m_we      = (m_rd[g] != '0);
      m_add     = m_rd[g];
      m_wdata   = m_dat[g];
      m_full[g] = 1'b0;
      if (tie) m_tie_winner = g;
    end else begin
      m_we = 1'b0;
    end
    if (acc0) begin
      m_full[0] = 1'b1; m_rd[0] = ard; m_dat[0] = adat; m_seq[0] = cycle_no * 2;
    end
    if (acc1) begin
      m_full[1] = 1'b1; m_rd[1] = lrd; m_dat[1] = ldat; m_seq[1] = cycle_no * 2 + 1;
    end
    cycle_no++;
    @(posedge clk);
  endtask

  task automatic idle(input int n, input logic [AW-1:0] b1);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, b1, '0);
  endtask

  task automatic resetAndCheck(input string tag);
    @(negedge clk);
    #2;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, "_rf_we"},     XLEN'(rf_we),     '0);
    checkOutput({tag, "_rf_w_add"},  XLEN'(rf_w_add),  '0);
    checkOutput({tag, "_rf_w_data"}, rf_w_data,        '0);
    checkOutput({tag, "_alu_ready"}, XLEN'(alu_ready), 32'd1);
    checkOutput({tag, "_lsu_ready"}, XLEN'(lsu_ready), 32'd1);
    checkOutput({tag, "_busy"},      XLEN'(busy),      '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    byp_add1 = '0; byp_add2 = '0;
    modelReset();
    resetAndCheck("por");

    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 5'd5, '0);
    idle(3, 5'd5);

    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 5'd1, 5'd2);
    idle(3, 5'd2);
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 5'd1, 5'd2);
    idle(3, 5'd1);

    applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 32'h55, 5'd0, 5'd0);
    idle(3, 5'd0);

    applyStimulus(1'b1, 5'd7, 32'hA, 1'b0, '0, '0, 5'd7, '0);
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 32'hB, 5'd7, '0);
    idle(3, 5'd7);

    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, AW'(8 + i % 4), XLEN'(32'h100 + i),
                    1'b1, AW'(12 + i % 4), XLEN'(32'h200 + i), AW'(8 + i % 8), AW'(12));
    idle(3, 5'd9);

    applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 5'd3, 5'd4);
    applyStimulus(1'b1, 5'd6, 32'h66, 1'b0, '0, '0, 5'd3, 5'd4);
    resetAndCheck("midflight");
    idle(4, 5'd4);

    for (int i = 0; i < 400; i++)
      applyStimulus(1'(($urandom_range(0, 9)) < 6), AW'($urandom_range(0, 7)), XLEN'($urandom),
                    1'(($urandom_range(0, 9)) < 6), AW'($urandom_range(0, 7)), XLEN'($urandom),
                    AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    idle(4, '0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
